run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 7 +
 rtl/clk_en_div.sv | 25 ++
 rtl/run_ctrl.sv | 67 ++++++
 tb/tb_run_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and default widths for the run controller
package run_ctrl_pkg;
  localparam int NIRQ_D  = 16;
  localparam int DIV_W_D = 32;
  localparam int CNT_W_D = 32;
  typedef enum logic [1:0] {RUN = 2'b00, SLEEP = 2'b01, HALT = 2'b10} state_t;
endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: registered clock-enable pulse once every div_i+1 clocks
module clk_en_div #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_en_o
);
  logic [DIV_W-1:0] r_cnt;
  logic             r_clk_en;
  logic             w_fire;
  // >= compare so a lowered divider fires at once instead of wrapping
  assign w_fire   = r_cnt >= div_i;
  assign clk_en_o = r_clk_en;
  // count up to the divider, then restart and emit one enable pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
    end else begin
      r_cnt    <= w_fire ? '0 : r_cnt + 1'b1;
      r_clk_en <= w_fire;
    end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: core run/sleep/halt control with interrupt capture and cycle counting
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int NIRQ  = NIRQ_D,
  parameter int DIV_W = DIV_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic [NIRQ-1:0]  irq_i,
  input  logic [NIRQ-1:0]  irq_mask_i,
  input  logic [NIRQ-1:0]  irq_ack_i,
  input  logic             halt_req_i,
  input  logic             sleep_req_i,
  output logic             clk_en_o,
  output logic             run_o,
  output logic [1:0]       state_o,
  output logic [NIRQ-1:0]  irq_pending_o,
  output logic             wake_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);
  state_t           r_state, w_next;
  logic [NIRQ-1:0]  r_pend;
  logic [CNT_W-1:0] r_cyc;
  logic             r_wake;
  logic             w_clk_en;
  logic             w_wake;

  clk_en_div #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .div_i   (div_i),
    .clk_en_o(w_clk_en)
  );

  assign clk_en_o      = w_clk_en;
  assign run_o         = r_state == RUN;
  assign state_o       = r_state;
  assign irq_pending_o = r_pend;
  assign wake_o        = r_wake;
  assign cycle_cnt_o   = r_cyc;

  // next state: halt beats everything, HALT is sticky, moves only on enable cycles
  always_comb begin
    w_next = !w_clk_en                          ? r_state :
             (r_state == HALT || halt_req_i)    ? HALT    :
             (r_state == RUN && sleep_req_i)    ? SLEEP   :
             (r_state == SLEEP && |r_pend)      ? RUN     : r_state;
    w_wake = r_state == SLEEP && w_next == RUN;
  end

  // state, sticky pending capture (set wins over ack), wake pulse, enabled-cycle count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RUN;
      r_pend  <= '0;
      r_wake  <= 1'b0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= (r_pend & ~irq_ack_i) | (irq_i & irq_mask_i);
      r_wake  <= w_wake;
      if (w_clk_en && r_state != HALT) r_cyc <= r_cyc + 1'b1;
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized and directed scoreboard bench for run_ctrl
module tb_run_ctrl;
  localparam int S_RUN = 0, S_SLEEP = 1, S_HALT = 2;

  typedef struct {
    bit        en;
    bit        run;
    bit [1:0]  st;
    bit [15:0] pend;
    bit        wake;
    bit [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] div_i = '0;
  logic [15:0] irq_i = '0, irq_mask_i = '0, irq_ack_i = '0;
  logic        halt_req_i = 1'b0, sleep_req_i = 1'b0;
  logic        clk_en_o, run_o, wake_o;
  logic [1:0]  state_o;
  logic [15:0] irq_pending_o;
  logic [31:0] cycle_cnt_o;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  longint unsigned m_cnt = 0;
  bit              m_en = 0, m_wake = 0;
  int              m_state = S_RUN;
  bit [15:0]       m_pend = '0;
  bit [31:0]       m_cyc = '0;

  run_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_i        (div_i),
    .irq_i        (irq_i),
    .irq_mask_i   (irq_mask_i),
    .irq_ack_i    (irq_ack_i),
    .halt_req_i   (halt_req_i),
    .sleep_req_i  (sleep_req_i),
    .clk_en_o     (clk_en_o),
    .run_o        (run_o),
    .state_o      (state_o),
    .irq_pending_o(irq_pending_o),
    .wake_o       (wake_o),
    .cycle_cnt_o  (cycle_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // one clock of stimulus: drive at negedge, advance the reference model, queue the expectation
  task automatic cyc(input bit rst, input int div, input bit [15:0] irq, input bit [15:0] mask,
                     input bit [15:0] ack, input bit halt, input bit sleep);
    exp_t e;
    int ns;
    bit ne, was_up;
    @(negedge clk);
    was_up = rst_n;
    rst_n = !rst; div_i = div; irq_i = irq; irq_mask_i = mask; irq_ack_i = ack;
    halt_req_i = halt; sleep_req_i = sleep;
    if (rst) begin
      m_cnt = 0; m_en = 0; m_state = S_RUN; m_pend = '0; m_wake = 0; m_cyc = '0;
    end else begin
      ne = m_cnt >= longint'(div);
      ns = m_state;
      m_wake = 0;
      if (m_en) begin
        if (m_state != S_HALT) m_cyc++;
        if (m_state == S_RUN) ns = halt ? S_HALT : sleep ? S_SLEEP : S_RUN;
        else if (m_state == S_SLEEP) ns = halt ? S_HALT : (m_pend != 0) ? S_RUN : S_SLEEP;
        m_wake = m_state == S_SLEEP && ns == S_RUN;
      end
      m_pend = (m_pend & ~ack) | (irq & mask);
      m_cnt = ne ? 0 : m_cnt + 1;
      m_en = ne;
      m_state = ns;
    end
    e.en = m_en; e.run = m_state == S_RUN; e.st = 2'(m_state);
    e.pend = m_pend; e.wake = m_wake; e.cyc = m_cyc;
    sb.push_back(e);
    if (rst && was_up) begin
      #1;
      chk("async_rst_run", run_o, 1);
      chk("async_rst_state", state_o, 0);
      chk("async_rst_pend", irq_pending_o, 0);
      chk("async_rst_cyc", cycle_cnt_o, 0);
      chk("async_rst_clk_en", clk_en_o, 0);
    end
  endtask

  task automatic idle(input int n, input int div, input bit [15:0] mask);
    for (int i = 0; i < n; i++) cyc(0, div, '0, mask, '0, 0, 0);
  endtask

  // monitor: compares every queued expectation against the outputs just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("clk_en", clk_en_o, e.en);
        chk("run", run_o, e.run);
        chk("state", state_o, e.st);
        chk("pending", irq_pending_o, e.pend);
        chk("wake", wake_o, e.wake);
        chk("cycle_cnt", cycle_cnt_o, e.cyc);
      end
    end
  end

  initial begin
    int n, div;
    bit [15:0] irq;
    cyc(1, 3, '0, '0, '0, 0, 0);
    cyc(1, 3, '0, '0, '0, 0, 0);
    idle(20, 3, '0);
    cyc(1, 0, '0, '0, '0, 0, 0);
    idle(3, 0, 16'h0020);
    cyc(0, 0, '0, 16'h0020, '0, 0, 1);
    idle(3, 0, 16'h0020);
    cyc(0, 0, 16'h0020, 16'h0020, '0, 0, 0);
    idle(4, 0, 16'h0020);
    cyc(1, 0, '0, '0, '0, 0, 0);
    idle(3, 0, '0);
    cyc(0, 0, '0, '0, '0, 0, 1);
    cyc(0, 0, 16'h0020, '0, '0, 0, 0);
    idle(5, 0, '0);
    cyc(1, 2, '0, '0, '0, 0, 0);
    idle(4, 2, '0);
    for (int i = 0; i < 3; i++) cyc(0, 2, '0, '1, '0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(0, 2, 16'($urandom), '1, '0, 0, 0);
    cyc(1, 2, '0, '0, '0, 0, 0);
    idle(3, 2, '0);
    cyc(0, 0, 16'h0004, '1, 16'h0004, 0, 0);
    cyc(0, 0, '0, '1, 16'h0004, 0, 0);
    cyc(0, 0, 16'h0008, '1, '0, 0, 0);
    cyc(0, 0, '0, '0, '0, 0, 0);
    cyc(1, 10, '0, '0, '0, 0, 0);
    n = 0;
    while (m_cnt != 8 && n < 30) begin
      cyc(0, 10, '0, '0, '0, 0, 0);
      n++;
    end
    chk("div_reach_8", m_cnt, 8);
    idle(12, 4, '0);
    cyc(1, 0, '0, '0, '0, 0, 0);
    div = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 30 == 0) div = $urandom_range(0, 4);
      irq = ($urandom_range(0, 5) == 0) ? 16'(1 << $urandom_range(0, 15)) : '0;
      cyc($urandom_range(0, 59) == 0, div, irq, 16'($urandom), 16'($urandom) & 16'($urandom),
          $urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0);
    end
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
